// File: rtl/column_drop_tracker.sv
// Purpose: tracks per-column piece counts of a drop-style game board and animates each falling piece.
// Latency: a drop accepted in cycle 0 lands (land_valid) in cycle (target+1)*FALL_TICKS+1.
// Backpressure: drop_ready is high only in IDLE; drops offered while busy are ignored silently.
module column_drop_tracker #(
    parameter int ROWS       = 6,
    parameter int COLS       = 7,
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3,
    parameter int FALL_TICKS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             drop_valid,
    input  logic [COL_W-1:0] drop_col,
    input  logic             drop_player,
    output logic             drop_ready,
    output logic             fall_active,
    output logic [ROW_W-1:0] fall_row,
    output logic [COL_W-1:0] fall_col,
    output logic             land_valid,
    output logic [ROW_W-1:0] land_row,
    output logic [COL_W-1:0] land_col,
    output logic             land_player,
    output logic [COLS-1:0]  col_full,
    output logic             board_full,
    output logic             illegal_drop
);

    localparam int TICK_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        LAND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  cnt [COLS];
    logic [ROW_W-1:0]  target;
    logic [TICK_W-1:0] tick;
    logic              player;

    logic              col_ok;
    logic [COL_W-1:0]  sel_col;
    logic              accept;
    logic              reject;
    logic              tick_last;
    logic              at_target;

    // Full flags are pure decodes of the counts, so they move in the same cycle as the count.
    for (genvar c = 0; c < COLS; c++) begin : g_full
        assign col_full[c] = (cnt[c] == ROW_W'(ROWS));
    end
    assign board_full = &col_full;

    // Out-of-range columns are steered to column 0 so no array is indexed past its end.
    assign col_ok    = (int'(drop_col) < COLS);
    assign sel_col   = col_ok ? drop_col : '0;
    assign accept    = (state == IDLE) && drop_valid && !clear && col_ok && !col_full[sel_col];
    assign reject    = (state == IDLE) && drop_valid && !clear && !(col_ok && !col_full[sel_col]);
    assign tick_last = (tick == TICK_W'(FALL_TICKS - 1));
    assign at_target = (fall_row >= target);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs; clear overrides every transition.
    always_comb begin
        state_nxt   = state;
        drop_ready  = 1'b0;
        fall_active = 1'b0;
        land_valid  = 1'b0;
        case (state)
            IDLE: begin
                drop_ready = 1'b1;
                if (accept) begin
                    state_nxt = FALL;
                end
            end
            FALL: begin
                fall_active = 1'b1;
                if (tick_last && at_target) begin
                    state_nxt = LAND;
                end
            end
            LAND: begin
                land_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // Datapath: counts, falling-piece position, tick counter and landing record.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < COLS; c++) begin
                cnt[c] <= '0;
            end
            target       <= '0;
            tick         <= '0;
            player       <= 1'b0;
            fall_row     <= '0;
            fall_col     <= '0;
            land_row     <= '0;
            land_col     <= '0;
            land_player  <= 1'b0;
            illegal_drop <= 1'b0;
        end else begin
            illegal_drop <= reject;
            if (clear) begin
                for (int c = 0; c < COLS; c++) begin
                    cnt[c] <= '0;
                end
                tick <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            fall_col <= drop_col;
                            player   <= drop_player;
                            target   <= ROW_W'(ROWS - 1) - cnt[sel_col];
                            fall_row <= '0;
                            tick     <= '0;
                        end
                    end
                    FALL: begin
                        if (tick_last) begin
                            tick <= '0;
                            if (!at_target) begin
                                fall_row <= fall_row + ROW_W'(1);
                            end else begin
                                // Saturating guard: a count never passes ROWS even if target were stale.
                                if (cnt[fall_col] != ROW_W'(ROWS)) begin
                                    cnt[fall_col] <= cnt[fall_col] + ROW_W'(1);
                                end
                                land_row    <= target;
                                land_col    <= fall_col;
                                land_player <= player;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_column_drop_tracker.sv
// Purpose: self-checking bench for column_drop_tracker with a queue-based scoreboard.
// Latency: expected landing cycles are queued at issue time and matched by a negedge monitor.
// Backpressure: stimulus waits for drop_ready (bounded) before issuing the next drop.
module tb_column_drop_tracker;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int ROW_W = 3;
    localparam int COL_W = 3;
    localparam int FT    = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             clear = 1'b0;
    logic             drop_valid = 1'b0;
    logic [COL_W-1:0] drop_col = '0;
    logic             drop_player = 1'b0;
    logic             drop_ready;
    logic             fall_active;
    logic [ROW_W-1:0] fall_row;
    logic [COL_W-1:0] fall_col;
    logic             land_valid;
    logic [ROW_W-1:0] land_row;
    logic [COL_W-1:0] land_col;
    logic             land_player;
    logic [COLS-1:0]  col_full;
    logic             board_full;
    logic             illegal_drop;

    column_drop_tracker #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .FALL_TICKS(FT)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .drop_valid(drop_valid), .drop_col(drop_col), .drop_player(drop_player),
        .drop_ready(drop_ready), .fall_active(fall_active), .fall_row(fall_row),
        .fall_col(fall_col), .land_valid(land_valid), .land_row(land_row),
        .land_col(land_col), .land_player(land_player), .col_full(col_full),
        .board_full(board_full), .illegal_drop(illegal_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        bit pl;
        int cyc;
        bit bf;
    } land_t;

    land_t land_q[$];
    int    ill_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a landing or a rejection.
    land_t me;
    int    mi;
    always @(negedge clk) begin
        if (resetn) begin
            if (land_valid) begin
                if (land_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_land: got row %0d col %0d, expected no landing (cycle %0d)",
                             land_row, land_col, cyc);
                end else begin
                    me = land_q.pop_front();
                    check("land_row", int'(land_row), me.row);
                    check("land_col", int'(land_col), me.col);
                    check("land_player", int'(land_player), int'(me.pl));
                    check("land_cycle", cyc, me.cyc);
                    check("board_full_at_land", int'(board_full), int'(me.bf));
                end
            end
            if (illegal_drop) begin
                if (ill_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_illegal: got illegal_drop=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mi = ill_q.pop_front();
                    check("illegal_cycle", cyc, mi);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (drop_ready) break;
            @(posedge clk);
            #1;
        end
        check("wait_idle_bound", int'(drop_ready), 1);
    endtask

    // exp_row < 0 means the drop must be rejected.
    task automatic do_drop(input int col, input bit pl, input int exp_row, input bit exp_bf);
        land_t e;
        @(posedge clk);
        #1;
        check("drop_ready_before", int'(drop_ready), 1);
        drop_col    = COL_W'(col);
        drop_player = pl;
        drop_valid  = 1'b1;
        if (exp_row >= 0) begin
            e.row = exp_row;
            e.col = col;
            e.pl  = pl;
            e.cyc = cyc + (exp_row + 1) * FT + 1;
            e.bf  = exp_bf;
            land_q.push_back(e);
        end else begin
            ill_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        check("fall_active_after_drop", int'(fall_active), (exp_row >= 0) ? 1 : 0);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_drop_ready"}, int'(drop_ready), 1);
        check({tag, "_fall_active"}, int'(fall_active), 0);
        check({tag, "_fall_row"}, int'(fall_row), 0);
        check({tag, "_fall_col"}, int'(fall_col), 0);
        check({tag, "_land_valid"}, int'(land_valid), 0);
        check({tag, "_land_row"}, int'(land_row), 0);
        check({tag, "_land_col"}, int'(land_col), 0);
        check({tag, "_land_player"}, int'(land_player), 0);
        check({tag, "_illegal_drop"}, int'(illegal_drop), 0);
        check({tag, "_col_full"}, int'(col_full), 0);
        check({tag, "_board_full"}, int'(board_full), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        land_t e;
        // Reset state.
        #2 resetn = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Single drop into empty column 3: trace fall_row and landing in cycle 25.
        @(posedge clk);
        #1;
        drop_col = 3'd3; drop_player = 1'b1; drop_valid = 1'b1;
        e.row = 5; e.col = 3; e.pl = 1'b1; e.cyc = cyc + 25; e.bf = 1'b0;
        land_q.push_back(e);
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        check("fall_col_col3", int'(fall_col), 3);
        for (int k = 1; k <= 24; k++) begin
            check("fall_row_trace", int'(fall_row), (k - 1) / FT);
            check("fall_active_trace", int'(fall_active), 1);
            check("drop_ready_busy", int'(drop_ready), 0);
            @(posedge clk);
            #1;
        end
        check("land_cycle_fall_active", int'(fall_active), 0);
        check("land_cycle_fall_row_hold", int'(fall_row), 5);
        check("land_cycle_col_full", int'(col_full), 0);
        wait_idle();

        // Six drops into column 0, then a seventh is rejected.
        do_drop(0, 1'b0, 5, 1'b0);
        do_drop(0, 1'b1, 4, 1'b0);
        do_drop(0, 1'b0, 3, 1'b0);
        do_drop(0, 1'b1, 2, 1'b0);
        do_drop(0, 1'b0, 1, 1'b0);
        do_drop(0, 1'b1, 0, 1'b0);
        check("col_full_after_six", int'(col_full), 7'h01);
        do_drop(0, 1'b0, -1, 1'b0);

        // Out-of-range column.
        do_drop(7, 1'b1, -1, 1'b0);
        check("drop_ready_after_col7", int'(drop_ready), 1);

        // Clear during the third FALL cycle.
        @(posedge clk);
        #1;
        drop_col = 3'd1; drop_player = 1'b0; drop_valid = 1'b1;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("fall_active_before_clear", int'(fall_active), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_fall_active", int'(fall_active), 0);
        check("clear_drop_ready", int'(drop_ready), 1);
        check("clear_col_full", int'(col_full), 0);
        do_drop(0, 1'b1, 5, 1'b0);

        // Clear wins over a simultaneous drop.
        @(posedge clk);
        #1;
        clear = 1'b1; drop_valid = 1'b1; drop_col = 3'd2;
        @(posedge clk);
        #1;
        clear = 1'b0; drop_valid = 1'b0;
        check("clear_prio_fall_active", int'(fall_active), 0);
        check("clear_prio_drop_ready", int'(drop_ready), 1);

        // Asynchronous reset in the middle of a fall.
        @(posedge clk);
        #1;
        drop_col = 3'd2; drop_player = 1'b1; drop_valid = 1'b1;
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check("pre_reset_fall_active", int'(fall_active), 1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midfall_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("drop_ready_after_release", int'(drop_ready), 1);
        do_drop(2, 1'b0, 5, 1'b0);

        // Fill the whole board; board_full rises in the landing cycle of the last piece.
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                do_drop(c, 1'((c + r) % 2), 5 - r, (c == COLS - 1) && (r == ROWS - 1));
            end
        end
        check("board_full_final", int'(board_full), 1);
        check("col_full_final", int'(col_full), 7'h7F);
        for (int c = 0; c <= COLS; c++) begin
            do_drop(c, 1'b0, -1, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("land_queue_empty", land_q.size(), 0);
        check("illegal_queue_empty", ill_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
